// File: rtl/bouncer_ball.sv
// Ball-motion engine: serves the ball, moves it on divided ticks, reflects
// off the walls and the paddle face, and counts paddle hits and misses.
module bouncer_ball #(
  parameter int DIV_BITS    = 17,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int STEP        = 4,
  parameter int PADDLE_X    = 20,
  parameter int PADDLE_W    = 4,
  parameter int PADDLE_LEN  = 60,
  parameter int START_X     = 320,
  parameter int START_Y     = 240,
  parameter int SERVE_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] linea_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       active,
  output logic       hit,
  output logic       miss,
  output logic [7:0] hit_count,
  output logic [3:0] miss_count
);

  localparam int SC_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);

  localparam logic [10:0] BS_W   = 11'(BALL_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] H_W    = 11'(H_RES);
  localparam logic [10:0] V_W    = 11'(V_RES);
  localparam logic [10:0] FACE_W = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] PLEN_W = 11'(PADDLE_LEN);

  localparam logic [9:0] STEP_P  = 10'(STEP);
  localparam logic [9:0] FACE_P  = 10'(PADDLE_X + PADDLE_W);
  localparam logic [9:0] X_MAX_P = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0] Y_MAX_P = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0] SX_P    = 10'(START_X);
  localparam logic [9:0] SY_P    = 10'(START_Y);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_RUN   = 2'd1,
    ST_MISS  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [SC_W-1:0]     serve_cnt_q, serve_cnt_d;
  logic [9:0]          ball_x_q, ball_x_d;
  logic [9:0]          ball_y_q, ball_y_d;
  logic                dir_x_q, dir_x_d;   // 1 = right
  logic                dir_y_q, dir_y_d;   // 1 = down
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic                active_q, active_d;
  logic [7:0]          hit_count_q, hit_count_d;
  logic [3:0]          miss_count_q, miss_count_d;

  logic                tick_s;
  logic [10:0]         bx_s, by_s, ly_s;
  logic [9:0]          x_nxt_s, y_nxt_s;
  logic                x_dir_s, y_dir_s;
  logic                x_hit_s, x_miss_s;
  logic                overlap_s;

  assign tick_s    = &div_q;
  assign bx_s      = {1'b0, ball_x_q};
  assign by_s      = {1'b0, ball_y_q};
  assign ly_s      = {1'b0, linea_y};
  assign overlap_s = (by_s + BS_W > ly_s) && (by_s < ly_s + PLEN_W);

  // Candidate per-axis move for a RUN tick; both axes resolve independently.
  always_comb begin
    y_nxt_s  = ball_y_q;
    y_dir_s  = dir_y_q;
    x_nxt_s  = ball_x_q;
    x_dir_s  = dir_x_q;
    x_hit_s  = 1'b0;
    x_miss_s = 1'b0;

    if (dir_y_q) begin
      if (by_s + BS_W + STEP_W >= V_W) begin
        y_nxt_s = Y_MAX_P;
        y_dir_s = 1'b0;
      end else begin
        y_nxt_s = ball_y_q + STEP_P;
      end
    end else begin
      if (by_s < STEP_W) begin
        y_nxt_s = 10'd0;
        y_dir_s = 1'b1;
      end else begin
        y_nxt_s = ball_y_q - STEP_P;
      end
    end

    if (dir_x_q) begin
      if (bx_s + BS_W + STEP_W >= H_W) begin
        x_nxt_s = X_MAX_P;
        x_dir_s = 1'b0;
      end else begin
        x_nxt_s = ball_x_q + STEP_P;
      end
    end else if ((bx_s >= FACE_W) && (bx_s < FACE_W + STEP_W)) begin
      // Paddle crossing wins over the wall; a non-overlap slips behind it.
      if (overlap_s) begin
        x_nxt_s = FACE_P;
        x_dir_s = 1'b1;
        x_hit_s = 1'b1;
      end else begin
        x_nxt_s = ball_x_q - STEP_P;
      end
    end else if (bx_s < STEP_W) begin
      x_miss_s = 1'b1;
    end else begin
      x_nxt_s = ball_x_q - STEP_P;
    end
  end

  // Next-state and output decode; ball state advances only on tick.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q + DIV_BITS'(1);
    serve_cnt_d  = serve_cnt_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    if (tick_s) begin
      case (state_q)
        ST_SERVE: begin
          if (serve_cnt_q == SC_W'(SERVE_TICKS - 1)) begin
            state_d = ST_RUN;
          end else begin
            serve_cnt_d = serve_cnt_q + SC_W'(1);
          end
        end
        ST_RUN: begin
          if (x_miss_s) begin
            miss_d  = 1'b1;
            state_d = ST_MISS;
            if (miss_count_q != 4'hF) begin
              miss_count_d = miss_count_q + 4'd1;
            end else begin
              miss_count_d = miss_count_q;
            end
          end else begin
            ball_x_d = x_nxt_s;
            ball_y_d = y_nxt_s;
            dir_x_d  = x_dir_s;
            dir_y_d  = y_dir_s;
            hit_d    = x_hit_s;
            if (x_hit_s && (hit_count_q != 8'hFF)) begin
              hit_count_d = hit_count_q + 8'd1;
            end else begin
              hit_count_d = hit_count_q;
            end
          end
        end
        ST_MISS: begin
          ball_x_d    = SX_P;
          ball_y_d    = SY_P;
          dir_x_d     = 1'b1;
          serve_cnt_d = '0;
          state_d     = ST_SERVE;
        end
        default: begin
          state_d = ST_SERVE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    active_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SERVE;
      div_q        <= '0;
      serve_cnt_q  <= '0;
      ball_x_q     <= SX_P;
      ball_y_q     <= SY_P;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      active_q     <= 1'b0;
      hit_count_q  <= 8'd0;
      miss_count_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      serve_cnt_q  <= serve_cnt_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      active_q     <= active_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign active     = active_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_bouncer_ball.sv
// Bench for bouncer_ball: a tick-level reference model of the game rules,
// a directed serve table, corner sequences, random paddle motion, saturation.
module tb_bouncer_ball;

  localparam int VR = 480, BS = 8, ST = 4, FACE = 24, PLEN = 60, SY = 240;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] linea_y = 10'd0;
  logic       sel = 1'b0;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_act, a_hit, a_miss, b_act, b_hit, b_miss;
  logic [7:0] a_hc, b_hc;
  logic [3:0] a_mc, b_mc;

  bouncer_ball #(.DIV_BITS(2), .SERVE_TICKS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .linea_y(linea_y),
    .ball_x(a_x), .ball_y(a_y), .active(a_act), .hit(a_hit), .miss(a_miss),
    .hit_count(a_hc), .miss_count(a_mc)
  );

  // Narrow field so long hit/miss runs stay short.
  bouncer_ball #(.DIV_BITS(2), .SERVE_TICKS(2), .H_RES(64), .START_X(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .linea_y(linea_y),
    .ball_x(b_x), .ball_y(b_y), .active(b_act), .hit(b_hit), .miss(b_miss),
    .hit_count(b_hc), .miss_count(b_mc)
  );

  logic [9:0] o_x, o_y;
  logic       o_act, o_hit, o_miss;
  logic [7:0] o_hc;
  logic [3:0] o_mc;
  assign o_x    = sel ? b_x    : a_x;
  assign o_y    = sel ? b_y    : a_y;
  assign o_act  = sel ? b_act  : a_act;
  assign o_hit  = sel ? b_hit  : a_hit;
  assign o_miss = sel ? b_miss : a_miss;
  assign o_hc   = sel ? b_hc   : a_hc;
  assign o_mc   = sel ? b_mc   : a_mc;

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int p_hres = 640, p_sx = 320;
  int mx, my, m_dx, m_dy, m_st, m_srv, m_hc, m_mc, m_hit, m_miss;
  int hit_events, miss_events;

  typedef struct { int ly; int x; int y; int act; } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = p_sx; my = SY; m_dx = 1; m_dy = 1; m_st = 0; m_srv = 0;
    m_hc = 0; m_mc = 0; m_hit = 0; m_miss = 0;
  endtask

  // One move tick of the game rules; m_st: 0 serve, 1 run, 2 miss.
  task automatic model_step(input int ly);
    int nx, ny, ndx, ndy;
    bit hitf, missf;
    m_hit = 0; m_miss = 0;
    if (m_st == 0) begin
      m_srv++;
      if (m_srv >= 2) m_st = 1;
    end else if (m_st == 2) begin
      mx = p_sx; my = SY; m_dx = 1; m_srv = 0; m_st = 0;
    end else begin
      nx = mx; ny = my; ndx = m_dx; ndy = m_dy; hitf = 0; missf = 0;
      if (m_dy == 1) begin
        if (my + BS + ST >= VR) begin ny = VR - BS; ndy = 0; end
        else ny = my + ST;
      end else begin
        if (my < ST) begin ny = 0; ndy = 1; end
        else ny = my - ST;
      end
      if (m_dx == 1) begin
        if (mx + BS + ST >= p_hres) begin nx = p_hres - BS; ndx = 0; end
        else nx = mx + ST;
      end else if (mx >= FACE && mx < FACE + ST) begin
        if (my + BS > ly && my < ly + PLEN) begin nx = FACE; ndx = 1; hitf = 1; end
        else nx = mx - ST;
      end else if (mx < ST) begin
        missf = 1;
      end else begin
        nx = mx - ST;
      end
      if (missf) begin
        m_miss = 1;
        if (m_mc < 15) m_mc++;
        m_st = 2;
      end else begin
        mx = nx; my = ny; m_dx = ndx; m_dy = ndy;
        if (hitf) begin
          m_hit = 1;
          if (m_hc < 255) m_hc++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ball_x", o_x, mx);
    chk("ball_y", o_y, my);
    chk("active", o_act, (m_st == 1) ? 1 : 0);
    chk("hit", o_hit, m_hit);
    chk("miss", o_miss, m_miss);
    chk("hit_count", o_hc, m_hc);
    chk("miss_count", o_mc, m_mc);
  endtask

  // Drive linea_y for one tick period; between ticks nothing may move.
  task automatic do_tick(input int ly);
    linea_y = 10'(ly);
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_hit", o_hit, 0);
      chk("idle_miss", o_miss, 0);
      chk("idle_x", o_x, mx);
      chk("idle_y", o_y, my);
    end
    @(posedge clk); #1;
    model_step(ly);
    check_all();
    if (m_hit == 1) hit_events++;
    if (m_miss == 1) miss_events++;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    for (int i = 0; i < 4; i++) begin
      do_tick(tbl[i].ly);
      chk("tbl_x", o_x, tbl[i].x);
      chk("tbl_y", o_y, tbl[i].y);
      chk("tbl_active", o_act, tbl[i].act);
    end
  endtask

  function automatic int track(input int y);
    return (y >= 10) ? y - 10 : 0;
  endfunction

  function automatic int avoid(input int y);
    return (y <= 392) ? 400 : 0;
  endfunction

  initial begin
    int prev_x, prev_y, budget, ly;
    bit seen_bot, seen_right, seen_behind;

    tbl[0] = '{0, 320, 240, 0};
    tbl[1] = '{0, 320, 240, 1};
    tbl[2] = '{0, 324, 244, 1};
    tbl[3] = '{0, 328, 248, 1};

    // Serve sequence on the full field.
    apply_reset();
    run_table();

    // Free run: bottom and right bounces, no paddle interaction.
    seen_bot = 0; seen_right = 0; budget = 0;
    while (!(seen_bot && seen_right) && budget < 200) begin
      prev_x = int'(o_x); prev_y = int'(o_y);
      do_tick(0);
      if (prev_y == 472 && int'(o_y) == 468) seen_bot = 1;
      if (prev_x == 632 && int'(o_x) == 628) seen_right = 1;
      budget++;
    end
    chk("bottom_bounce_seen", seen_bot, 1);
    chk("right_bounce_seen", seen_right, 1);
    chk("free_run_hc", o_hc, 0);
    chk("free_run_mc", o_mc, 0);

    // Paddle tracks the ball: first hit.
    hit_events = 0; budget = 0;
    while (hit_events == 0 && budget < 400) begin
      do_tick(track(my));
      budget++;
    end
    chk("hit_reached", hit_events, 1);
    chk("hit_x", o_x, 24);
    chk("hit_pulse", o_hit, 1);
    chk("hit_count_1", o_hc, 1);
    do_tick(track(my));
    chk("after_hit_x", o_x, 28);

    // Paddle parked away: ball slips behind it and misses.
    miss_events = 0; budget = 0; seen_behind = 0;
    while (miss_events == 0 && budget < 600) begin
      do_tick(avoid(my));
      if (m_st == 1 && int'(o_x) < FACE) seen_behind = 1;
      budget++;
    end
    chk("miss_reached", miss_events, 1);
    chk("passed_behind", seen_behind, 1);
    chk("miss_pulse", o_miss, 1);
    chk("miss_count_1", o_mc, 1);
    chk("miss_active", o_act, 0);
    chk("miss_no_extra_hit", o_hc, 1);
    do_tick(0);
    chk("reserve_x", o_x, 320);
    chk("reserve_y", o_y, 240);
    chk("reserve_active", o_act, 0);

    // Build up to three hits, then reset asynchronously mid-RUN.
    budget = 0;
    while (m_hc < 3 && budget < 1500) begin
      do_tick(track(my));
      budget++;
    end
    do_tick(track(my));
    do_tick(track(my));
    chk("pre_reset_hc", o_hc, 3);
    chk("pre_reset_active", o_act, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_table();

    // Random paddle positions, some near the ball, some far away.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: ly = int'($urandom_range(0, 1023));
        1: begin
          ly = my - int'($urandom_range(0, 70));
          if (ly < 0) ly = 0;
        end
        default: ly = avoid(my);
      endcase
      do_tick(ly);
    end

    // Saturation runs on the narrow field.
    sel = 1'b1; p_hres = 64; p_sx = 32;
    apply_reset();
    miss_events = 0; budget = 0;
    while (miss_events < 17 && budget < 1500) begin
      do_tick(avoid(my));
      budget++;
    end
    chk("miss_events_17", miss_events, 17);
    chk("miss_count_sat", o_mc, 15);
    hit_events = 0; budget = 0;
    while (hit_events < 300 && budget < 8000) begin
      do_tick(track(my));
      budget++;
    end
    chk("hit_events_300", hit_events, 300);
    chk("hit_count_sat", o_hc, 255);
    chk("miss_count_held", o_mc, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
